// File: rtl/safe_digit_sender.sv
// safe_digit_sender: replays a latched multi-digit code as timed (digit, valid) strobes.
// A leading gap guarantees the receiver sees valid low before the first digit; each
// digit is then held valid for HOLD_CYCLES and followed by GAP_CYCLES of valid low.
module safe_digit_sender #(
  parameter int unsigned NUM_DIGITS  = 6,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4*NUM_DIGITS-1:0] code,
  output logic [3:0]              digit_out,
  output logic                    valid,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              digit_idx
);

  localparam int unsigned CodeW = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       LastIdx  = 3'(NUM_DIGITS - 1);

  // Reject illegal parameterisations at elaboration.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("safe_digit_sender: NUM_DIGITS must be in 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("safe_digit_sender: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("safe_digit_sender: GAP_CYCLES must be >= 1");
  end
  if (CNT_W < 32 && (HOLD_CYCLES > (1 << CNT_W) || GAP_CYCLES > (1 << CNT_W)))
  begin : g_bad_cnt_w
    $error("safe_digit_sender: CNT_W too narrow for HOLD_CYCLES/GAP_CYCLES");
  end

  typedef enum logic [2:0] {StIdle, StLead, StHold, StGap, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [CodeW-1:0]   shreg_q, shreg_d;
  logic [3:0]         digit_q, digit_d;
  logic               valid_q, busy_q, done_q;

  // Next-state logic: phase counter, digit index and the MS-first digit shifter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    digit_d = digit_q;

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        idx_d   = '0;
        digit_d = '0;
        if (start) begin
          shreg_d = code;
          state_d = StLead;
        end
      end
      StLead: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          digit_d = shreg_q[CodeW-1 -: 4];
          shreg_d = shreg_q << 4;
          state_d = StHold;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 3'd1;
            digit_d = shreg_q[CodeW-1 -: 4];
            shreg_d = shreg_q << 4;
            state_d = StHold;
          end
        end
      end
      StDone: begin
        cnt_d   = '0;
        idx_d   = '0;
        digit_d = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        digit_d = '0;
        state_d = StIdle;
      end
    endcase

    // Abort only matters while a sequence is actually running.
    if (abort && (state_q == StLead || state_q == StHold || state_q == StGap)) begin
      cnt_d   = '0;
      idx_d   = '0;
      digit_d = '0;
      state_d = StIdle;
    end
  end

  // State and registered outputs; strobes are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      digit_q <= digit_d;
      valid_q <= (state_d == StHold);
      busy_q  <= (state_d == StLead) || (state_d == StHold) || (state_d == StGap);
      done_q  <= (state_d == StDone);
    end
  end

  assign digit_out = digit_q;
  assign digit_idx = idx_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
